pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller for the 8-bit program counter register, which has no enable input.
- Every cycle it computes the PC register's next-value input from a set of sources:
  - sequential increment
  - branch target
  - jump / call target
  - return
  - interrupt vector
  - hold (stall)
- Sits between decode/execute and the PC register. Owns boot, halt and interrupt sequencing.
- Emits a flush pulse to the fetch/decode stages on every redirect.

Parameters:
- PC_W, 8, program counter width.
- RESET_VEC, 8'h00, first fetch address after reset.
- IRQ_VEC, 8'h04, interrupt handler entry address.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN; power of two).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- pc  in  PC_W  current value of the PC register.
- stall  in  1  hold PC (hazard/memory wait).
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  PC_W  branch destination.
- jump  in  1  unconditional jump.
- call  in  1  subroutine call.
- jump_target  in  PC_W  jump/call destination.
- ret  in  1  subroutine return.
- iret  in  1  return from interrupt.
- halt  in  1  halt instruction executed.
- irq  in  1  level interrupt request.
- pc_next  out  PC_W  next-value input to the PC register.
- flush  out  1  one-cycle pulse, a redirect was taken.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- in_isr  out  1  handler active.
- halted  out  1  state == HALT.
- ras_err  out  1  one-cycle pulse, RAS underflow/overflow (0 when feature off).

Behaviour:
- Reset (rst==0 at posedge):
  - state=BOOT; epc=0; in_isr=0; RAS pointer=0, empty.
  - flush=irq_ack=ras_err=0.
  - pc_next = RESET_VEC combinationally while in reset and in BOOT.
- FSM states: BOOT, RUN, HALT, ISR_ENTRY.
- BOOT: one cycle; pc_next=RESET_VEC; goes to RUN.
- RUN, stall=1: pc_next=pc. All redirect inputs are ignored; the pipeline re-presents them. A pending irq waits.
- RUN, stall=0, priority highest first:
  1. irq & ~in_isr → ISR_ENTRY. epc<=pc; pc_next=IRQ_VEC; flush=1.
  2. iret & in_isr → pc_next=epc; in_isr<=0; flush=1. iret while ~in_isr is ignored (treated as sequential).
  3. ret → see Optional Feature; flush=1.
  4. call or jump → pc_next=jump_target; flush=1.
  5. branch_taken → pc_next=branch_target; flush=1.
  6. halt → HALT; pc_next=pc.
  7. otherwise pc_next=pc+1, modulo 2^PC_W (8'hFF wraps to 8'h00, no flag).
- ISR_ENTRY: one cycle; irq_ack=1; in_isr<=1; pc_next=pc (already IRQ_VEC); goes to RUN.
- HALT:
  - pc_next=pc; halted=1.
  - irq=1 → epc<=pc+1 (resume after the halt), pc_next=IRQ_VEC, flush=1, go to ISR_ENTRY.
  - No other exit except reset.
- Nested interrupts are not supported; irq is masked while in_isr=1.
- Reset mid-ISR or mid-HALT returns to BOOT and clears all state.
- flush, irq_ack and ras_err are registered-free combinational pulses, valid in the redirect cycle only.

Optional Feature:
- Macro PC_RAS_EN.
- Defined: hardware return-address stack of RAS_DEPTH entries.
  - call pushes pc+1.
  - ret pops and sets pc_next=top.
  - Push when full overwrites the oldest entry (circular) and pulses ras_err.
  - Pop when empty: pc_next=jump_target, ras_err=1.
  - call and ret together: ret wins, no push.
- Undefined: no stack storage.
  - ret behaves as a jump to jump_target (software link register).
  - call behaves as a jump.
  - ras_err is tied to 0.

Decomposition:
- Package pc_seq_pkg: state enum (BOOT, RUN, HALT, ISR_ENTRY), PC_W default, RESET_VEC and IRQ_VEC default constants.
- Sub-module pc_ras:
  - Push/pop/full/empty/top interface.
  - Instantiated only under PC_RAS_EN.

Test Plan:
- Reset release, no inputs → pc_next=00 in BOOT, then 01, 02, …; pc=FF → pc_next=00.
- pc=10, branch_taken=1, branch_target=40, jump=1, jump_target=80 in the same cycle → pc_next=80, flush=1.
- pc=20, stall=1, branch_taken=1 → pc_next=20, flush=0; stall dropped with branch held → pc_next=branch_target.
- pc=30, irq=1 → pc_next=04, epc=30, irq_ack next cycle, in_isr=1; second irq ignored; iret → pc_next=30, in_isr=0.
- halt at pc=50 → halted=1, pc_next=50 held; irq → pc_next=04; later iret → pc_next=51.
- PC_RAS_EN, depth 4: five calls from pc=10,20,30,40,50 → ras_err on fifth; four rets → 51,41,31,21; fifth ret → ras_err, pc_next=jump_target.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared FSM state type and default constants for the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT, ISR_ENTRY} state_t;
  localparam int PC_W_DEF = 8;
  localparam logic [7:0] RESET_VEC_DEF = 8'h00;
  localparam logic [7:0] IRQ_VEC_DEF = 8'h04;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/execute-side request bus and PC-register-side result bus of the sequencer
interface pc_sequencer_if import pc_seq_pkg::*; #(parameter int PC_W = PC_W_DEF) ();
  logic [PC_W-1:0] i_pc;
  logic            i_stall;
  logic            i_branch_taken;
  logic [PC_W-1:0] i_branch_target;
  logic            i_jump;
  logic            i_call;
  logic [PC_W-1:0] i_jump_target;
  logic            i_ret;
  logic            i_iret;
  logic            i_halt;
  logic            i_irq;
  logic [PC_W-1:0] o_pc_next;
  logic            o_flush;
  logic            o_irq_ack;
  logic            o_in_isr;
  logic            o_halted;
  logic            o_ras_err;
  modport master (
    output i_pc, i_stall, i_branch_taken, i_branch_target, i_jump, i_call,
           i_jump_target, i_ret, i_iret, i_halt, i_irq,
    input  o_pc_next, o_flush, o_irq_ack, o_in_isr, o_halted, o_ras_err
  );
  modport slave (
    input  i_pc, i_stall, i_branch_taken, i_branch_target, i_jump, i_call,
           i_jump_target, i_ret, i_iret, i_halt, i_irq,
    output o_pc_next, o_flush, o_irq_ack, o_in_isr, o_halted, o_ras_err
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_do_pop;
  logic          w_do_push;
  assign o_full    = r_cnt == CW'(DEPTH);
  assign o_empty   = r_cnt == '0;
  assign o_top     = r_mem[r_ptr - 1'b1];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && !w_do_pop;
  // write pointer and occupancy; occupancy saturates at DEPTH while the pointer keeps wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + 1'b1;
      r_cnt <= o_full ? r_cnt : r_cnt + 1'b1;
    end
  end
  // entry storage, written at the pointer slot (the oldest entry once full)
  always_ff @(posedge clk) begin
    if (rst && w_do_push) r_mem[r_ptr] <= i_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with boot/halt/interrupt sequencing; PC_RAS_EN adds a hardware return-address stack
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(IRQ_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two of at least 2");
  end
  state_t          r_state;
  state_t          w_state_nx;
  logic [PC_W-1:0] r_epc;
  logic            r_in_isr;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_epc_d;
  logic            w_epc_we;
  logic            w_isr_set;
  logic            w_isr_clr;
  logic            w_flush;
  logic            w_irq_ack;
  logic            w_ras_err;
`ifdef PC_RAS_EN
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_full;
  logic            w_ras_empty;
  pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );
`endif
  assign w_pc_inc = bus.i_pc + 1'b1;
  // state, saved return PC and handler-active flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= BOOT;
      r_epc    <= '0;
      r_in_isr <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_epc_we) r_epc <= w_epc_d;
      if (w_isr_set) r_in_isr <= 1'b1;
      else if (w_isr_clr) r_in_isr <= 1'b0;
    end
  end
  // next-state and next-PC selection; redirects in RUN are taken in fixed priority order
  always_comb begin
    w_state_nx = r_state;
    w_pc_next  = bus.i_pc;
    w_epc_d    = bus.i_pc;
    w_epc_we   = 1'b0;
    w_isr_set  = 1'b0;
    w_isr_clr  = 1'b0;
    w_flush    = 1'b0;
    w_irq_ack  = 1'b0;
    w_ras_err  = 1'b0;
`ifdef PC_RAS_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
`endif
    case (r_state)
      BOOT: begin
        w_pc_next  = RESET_VEC;
        w_state_nx = RUN;
      end
      ISR_ENTRY: begin
        w_irq_ack  = 1'b1;
        w_isr_set  = 1'b1;
        w_state_nx = RUN;
      end
      HALT: begin
        if (bus.i_irq && !r_in_isr) begin
          w_epc_we   = 1'b1;
          w_epc_d    = w_pc_inc;
          w_pc_next  = IRQ_VEC;
          w_flush    = 1'b1;
          w_state_nx = ISR_ENTRY;
        end
      end
      default: begin
        if (!bus.i_stall) begin
          if (bus.i_irq && !r_in_isr) begin
            w_epc_we   = 1'b1;
            w_pc_next  = IRQ_VEC;
            w_flush    = 1'b1;
            w_state_nx = ISR_ENTRY;
          end else if (bus.i_iret && r_in_isr) begin
            w_pc_next = r_epc;
            w_isr_clr = 1'b1;
            w_flush   = 1'b1;
          end else if (bus.i_ret) begin
            w_flush   = 1'b1;
`ifdef PC_RAS_EN
            w_pc_next = w_ras_empty ? bus.i_jump_target : w_ras_top;
            w_ras_err = w_ras_empty;
            w_pop     = !w_ras_empty;
`else
            w_pc_next = bus.i_jump_target;
`endif
          end else if (bus.i_call || bus.i_jump) begin
            w_pc_next = bus.i_jump_target;
            w_flush   = 1'b1;
`ifdef PC_RAS_EN
            w_push    = bus.i_call;
            w_ras_err = bus.i_call && w_ras_full;
`endif
          end else if (bus.i_branch_taken) begin
            w_pc_next = bus.i_branch_target;
            w_flush   = 1'b1;
          end else if (bus.i_halt) begin
            w_state_nx = HALT;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end
    endcase
    if (!rst) begin
      w_pc_next = RESET_VEC;
      w_flush   = 1'b0;
      w_irq_ack = 1'b0;
      w_ras_err = 1'b0;
    end
  end
  assign bus.o_pc_next = w_pc_next;
  assign bus.o_flush   = w_flush;
  assign bus.o_irq_ack = w_irq_ack;
  assign bus.o_in_isr  = r_in_isr;
  assign bus.o_halted  = r_state == HALT;
  assign bus.o_ras_err = w_ras_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table vectors, stack corner sequence and randomized run against a queue-based reference model
module tb_pc_sequencer;
  localparam int DEPTH = 4;
  localparam logic [7:0] RV = 8'h00;
  localparam logic [7:0] IV = 8'h04;
  localparam logic [7:0] S = 8'h80, B = 8'h40, J = 8'h20, C = 8'h10;
  localparam logic [7:0] R = 8'h08, IR = 8'h04, H = 8'h02, Q = 8'h01;
  localparam logic [4:0] F = 5'b10000, A = 5'b01000, I = 5'b00100, HL = 5'b00010, E = 5'b00001;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_ENTRY = 3;
`ifdef PC_RAS_EN
  localparam logic [7:0] RET_EXP = 8'h61;
`else
  localparam logic [7:0] RET_EXP = 8'hB0;
`endif
  typedef struct {
    logic       rst;
    logic [7:0] pc;
    logic [7:0] ctl;
    logic [7:0] bt;
    logic [7:0] jt;
  } in_t;
  typedef struct {
    in_t        i;
    logic [7:0] pc_next;
    logic [4:0] outs;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  in_t  cur;
  vec_t tbl[$];
  int         m_mode, n_mode;
  logic [7:0] m_epc, n_epc;
  logic       m_isr, n_isr;
  logic [7:0] m_stk[$];
  logic [7:0] n_stk[$];
  logic [7:0] e_pc;
  logic       e_fl, e_ack, e_err;
  pc_sequencer_if #(.PC_W(8)) bus ();
  pc_sequencer #(.PC_W(8), .RESET_VEC(RV), .IRQ_VEC(IV), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic drive(input in_t v);
    cur                = v;
    rst                = v.rst;
    bus.i_pc           = v.pc;
    bus.i_stall        = v.ctl[7];
    bus.i_branch_taken = v.ctl[6];
    bus.i_jump         = v.ctl[5];
    bus.i_call         = v.ctl[4];
    bus.i_ret          = v.ctl[3];
    bus.i_iret         = v.ctl[2];
    bus.i_halt         = v.ctl[1];
    bus.i_irq          = v.ctl[0];
    bus.i_branch_target = v.bt;
    bus.i_jump_target  = v.jt;
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_eval();
    logic stall, br, jump, call, ret, iret, halt, irq;
    {stall, br, jump, call, ret, iret, halt, irq} = cur.ctl;
    n_mode = m_mode;
    n_epc  = m_epc;
    n_isr  = m_isr;
    n_stk  = m_stk;
    e_pc   = cur.pc;
    e_fl   = 1'b0;
    e_ack  = 1'b0;
    e_err  = 1'b0;
    if (!cur.rst) begin
      e_pc   = RV;
      n_mode = M_BOOT;
      n_epc  = 8'h00;
      n_isr  = 1'b0;
      n_stk  = {};
    end else if (m_mode == M_BOOT) begin
      e_pc   = RV;
      n_mode = M_RUN;
    end else if (m_mode == M_ENTRY) begin
      e_ack  = 1'b1;
      n_isr  = 1'b1;
      n_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (irq && !m_isr) begin
        n_epc  = 8'((int'(cur.pc) + 1) % 256);
        e_pc   = IV;
        e_fl   = 1'b1;
        n_mode = M_ENTRY;
      end
    end else if (!stall) begin
      if (irq && !m_isr) begin
        n_epc  = cur.pc;
        e_pc   = IV;
        e_fl   = 1'b1;
        n_mode = M_ENTRY;
      end else if (iret && m_isr) begin
        e_pc  = m_epc;
        n_isr = 1'b0;
        e_fl  = 1'b1;
      end else if (ret) begin
        e_fl = 1'b1;
        e_pc = cur.jt;
`ifdef PC_RAS_EN
        if (n_stk.size() == 0) e_err = 1'b1;
        else e_pc = n_stk.pop_back();
`endif
      end else if (call || jump) begin
        e_pc = cur.jt;
        e_fl = 1'b1;
`ifdef PC_RAS_EN
        if (call) begin
          n_stk.push_back(8'((int'(cur.pc) + 1) % 256));
          if (n_stk.size() > DEPTH) begin
            void'(n_stk.pop_front());
            e_err = 1'b1;
          end
        end
`endif
      end else if (br) begin
        e_pc = cur.bt;
        e_fl = 1'b1;
      end else if (halt) begin
        n_mode = M_HALT;
      end else begin
        e_pc = 8'((int'(cur.pc) + 1) % 256);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m_mode = n_mode;
    m_epc  = n_epc;
    m_isr  = n_isr;
    m_stk  = n_stk;
    @(negedge clk);
  endtask
  task automatic add(input logic r, input logic [7:0] pc, input logic [7:0] ctl, input logic [7:0] bt,
                     input logic [7:0] jt, input logic [7:0] epc, input logic [4:0] eo);
    vec_t v;
    v.i.rst = r;
    v.i.pc  = pc;
    v.i.ctl = ctl;
    v.i.bt  = bt;
    v.i.jt  = jt;
    v.pc_next = epc;
    v.outs    = eo;
    tbl.push_back(v);
  endtask
  task automatic run_tbl(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      #1;
      model_eval();
      chk($sformatf("%s[%0d].pc_next", tag, k), bus.o_pc_next, tbl[k].pc_next);
      chk($sformatf("%s[%0d].flush", tag, k), 8'(bus.o_flush), 8'(tbl[k].outs[4]));
      chk($sformatf("%s[%0d].irq_ack", tag, k), 8'(bus.o_irq_ack), 8'(tbl[k].outs[3]));
      chk($sformatf("%s[%0d].in_isr", tag, k), 8'(bus.o_in_isr), 8'(tbl[k].outs[2]));
      chk($sformatf("%s[%0d].halted", tag, k), 8'(bus.o_halted), 8'(tbl[k].outs[1]));
      chk($sformatf("%s[%0d].ras_err", tag, k), 8'(bus.o_ras_err), 8'(tbl[k].outs[0]));
      tick();
    end
    tbl.delete();
  endtask
  initial begin
    in_t v;
    v = '{rst: 1'b0, pc: 8'h00, ctl: 8'h00, bt: 8'h00, jt: 8'h00};
    drive(v);
    m_mode = M_BOOT;
    m_epc  = 8'h00;
    m_isr  = 1'b0;
    m_stk  = {};
    @(negedge clk);
    add(0, 8'h33, 0, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 8'h01, 0);
    add(1, 8'h01, 0, 0, 0, 8'h02, 0);
    add(1, 8'hFF, 0, 0, 0, 8'h00, 0);
    add(1, 8'h10, B | J, 8'h40, 8'h80, 8'h80, F);
    add(1, 8'h20, S | B, 8'h44, 0, 8'h20, 0);
    add(1, 8'h20, B, 8'h44, 0, 8'h44, F);
    add(1, 8'h30, Q, 0, 0, 8'h04, F);
    add(1, 8'h04, Q, 0, 0, 8'h04, A);
    add(1, 8'h04, Q, 0, 0, 8'h05, I);
    add(1, 8'h05, IR, 0, 0, 8'h30, F | I);
    add(1, 8'h30, 0, 0, 0, 8'h31, 0);
    add(1, 8'h50, H, 0, 0, 8'h50, 0);
    add(1, 8'h50, 0, 0, 0, 8'h50, HL);
    add(1, 8'h50, J | B | R | C, 8'h11, 8'h99, 8'h50, HL);
    add(1, 8'h50, Q, 0, 0, 8'h04, F | HL);
    add(1, 8'h04, 0, 0, 0, 8'h04, A);
    add(1, 8'h04, 0, 0, 0, 8'h05, I);
    add(1, 8'h05, IR, 0, 0, 8'h51, F | I);
    add(1, 8'h51, IR, 0, 0, 8'h52, 0);
    add(1, 8'h60, C, 0, 8'hA0, 8'hA0, F);
    add(1, 8'h70, R, 0, 8'hB0, RET_EXP, F);
    add(1, 8'h70, Q, 0, 0, 8'h04, F);
    add(1, 8'h04, 0, 0, 0, 8'h04, A);
    add(1, 8'h04, 0, 0, 0, 8'h05, I);
    add(0, 8'h05, Q, 0, 0, 8'h00, I);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 8'h01, 0);
    run_tbl("tbl");
    add(0, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0);
`ifdef PC_RAS_EN
    add(1, 8'h10, C, 0, 8'hC0, 8'hC0, F);
    add(1, 8'h20, C, 0, 8'hC0, 8'hC0, F);
    add(1, 8'h30, C, 0, 8'hC0, 8'hC0, F);
    add(1, 8'h40, C, 0, 8'hC0, 8'hC0, F);
    add(1, 8'h50, C, 0, 8'hC0, 8'hC0, F | E);
    add(1, 8'h90, R, 0, 8'hD0, 8'h51, F);
    add(1, 8'h90, R, 0, 8'hD0, 8'h41, F);
    add(1, 8'h90, R | C, 0, 8'hD0, 8'h31, F);
    add(1, 8'h90, R, 0, 8'hD0, 8'h21, F);
    add(1, 8'h90, R, 0, 8'hD0, 8'hD0, F | E);
`else
    add(1, 8'h10, R, 0, 8'hD0, 8'hD0, F);
    add(1, 8'h20, C, 0, 8'hC0, 8'hC0, F);
    add(1, 8'hC0, R, 0, 8'hD4, 8'hD4, F);
    add(1, 8'hD4, R | C, 0, 8'hE0, 8'hE0, F);
`endif
    run_tbl("ras");
    for (int n = 0; n < 3000; n++) begin
      v.rst = $urandom_range(99) != 0;
      v.pc  = 8'($urandom);
      v.bt  = 8'($urandom);
      v.jt  = 8'($urandom);
      v.ctl = {$urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(9) == 0,
               $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(7) == 0,
               $urandom_range(19) == 0, $urandom_range(7) == 0};
      drive(v);
      #1;
      model_eval();
      chk($sformatf("rnd[%0d].pc_next", n), bus.o_pc_next, e_pc);
      chk($sformatf("rnd[%0d].flush", n), 8'(bus.o_flush), 8'(e_fl));
      chk($sformatf("rnd[%0d].irq_ack", n), 8'(bus.o_irq_ack), 8'(e_ack));
      chk($sformatf("rnd[%0d].ras_err", n), 8'(bus.o_ras_err), 8'(e_err));
      chk($sformatf("rnd[%0d].in_isr", n), 8'(bus.o_in_isr), 8'(m_isr));
      chk($sformatf("rnd[%0d].halted", n), 8'(bus.o_halted), 8'(m_mode == M_HALT));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
